// File: rtl/pool_window_engine_if.sv
// Handshake and BRAM-port bundle between a frame controller and pool_window_engine.
// The engine connects through the slave modport.
interface pool_window_engine_if #(
  parameter int DATA_W     = 8,
  parameter int ADDR_IN_W  = 10,
  parameter int ADDR_OUT_W = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_IN_W-1:0]  rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en;
  logic [ADDR_OUT_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;

  modport slave (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_window_engine.sv
// Max-pool engine: streams a CHANNELS x IMG_H x IMG_W map from the conv2 BRAM in
// non-overlapping POOL_K x POOL_K windows and writes each signed window maximum in order.
module pool_window_engine #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int CHANNELS   = 1,
  parameter int POOL_K     = 2,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int ADDR_IN_W  = 10,
  parameter int ADDR_OUT_W = 8
) (
  input logic                clk,
  input logic                rstn,
  pool_window_engine_if.slave bus
);

  localparam int OW    = IMG_W / POOL_K;
  localparam int OH    = IMG_H / POOL_K;
  localparam int N_IN  = CHANNELS * IMG_W * IMG_H;
  localparam int N_OUT = CHANNELS * OW * OH;
  localparam int KW    = $clog2(POOL_K);
  localparam int OXW   = (OW > 1) ? $clog2(OW) : 1;
  localparam int OYW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [KW-1:0]         K_MAX    = KW'(POOL_K - 1);
  localparam logic [OXW-1:0]        OX_MAX   = OXW'(OW - 1);
  localparam logic [OYW-1:0]        OY_MAX   = OYW'(OH - 1);
  localparam logic [CW-1:0]         C_MAX    = CW'(CHANNELS - 1);
  localparam logic [ADDR_OUT_W-1:0] LAST_OUT = ADDR_OUT_W'(N_OUT - 1);
  // Address jumps: end of a window row to the next row, and end of a window to the next window.
  // Every other step (window rows, image rows, channels) is contiguous, so +1.
  localparam logic [ADDR_IN_W-1:0]  STEP_ROW = ADDR_IN_W'(IMG_W - POOL_K + 1);
  localparam logic [ADDR_IN_W-1:0]  STEP_WIN = ADDR_IN_W'(1 - (POOL_K - 1) * IMG_W);

  if (IMG_W % POOL_K != 0) begin : g_bad_w
    $error("IMG_W must be a multiple of POOL_K");
  end
  if (IMG_H % POOL_K != 0) begin : g_bad_h
    $error("IMG_H must be a multiple of POOL_K");
  end
  if (POOL_K < 2 || POOL_K > 4) begin : g_bad_k
    $error("POOL_K must be in 2..4");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("RD_LAT must be in 1..3");
  end
  if (ADDR_IN_W < $clog2(N_IN)) begin : g_bad_ain
    $error("ADDR_IN_W too narrow for the feature map");
  end
  if (ADDR_OUT_W < $clog2(N_OUT)) begin : g_bad_aout
    $error("ADDR_OUT_W too narrow for the pooled map");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            kx_q, kx_d, ky_q, ky_d;
  logic [OXW-1:0]           ox_q, ox_d;
  logic [OYW-1:0]           oy_q, oy_d;
  logic [CW-1:0]            c_q, c_d;
  logic [ADDR_IN_W-1:0]     rd_addr_q, rd_addr_d;
  tag_t                     tag_q [RD_LAT];
  tag_t                     tag_in, tag_out;
  logic signed [DATA_W-1:0] acc_q, acc_d, rd_sample, win_max;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_OUT_W-1:0]    wr_addr_q, wr_addr_d, out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;

  logic rd_en, launch, kx_max, ky_max, ox_max, oy_max, c_max, read_last;

  assign rd_en     = (state_q == RUN);
  assign launch    = (state_q == IDLE) && bus.start;
  assign kx_max    = (kx_q == K_MAX);
  assign ky_max    = (ky_q == K_MAX);
  assign ox_max    = (ox_q == OX_MAX);
  assign oy_max    = (oy_q == OY_MAX);
  assign c_max     = (c_q == C_MAX);
  assign read_last = kx_max && ky_max && ox_max && oy_max && c_max;

  assign tag_in  = '{valid: rd_en,
                     first: rd_en && (kx_q == '0) && (ky_q == '0),
                     last:  rd_en && kx_max && ky_max};
  assign tag_out = tag_q[RD_LAT-1];

  assign rd_sample = bus.rd_data;
  assign win_max   = (rd_sample > acc_q) ? rd_sample : acc_q;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (read_last) state_d = DRAIN;
      DRAIN:   if (wr_en_q && (wr_addr_q == LAST_OUT)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window walk: kx fastest, then ky, ox, oy, c. Counters freeze on the final read.
  always_comb begin
    kx_d      = kx_q;
    ky_d      = ky_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    c_d       = c_q;
    rd_addr_d = rd_addr_q;
    if (launch) begin
      kx_d      = '0;
      ky_d      = '0;
      ox_d      = '0;
      oy_d      = '0;
      c_d       = '0;
      rd_addr_d = '0;
    end else if (rd_en && !read_last) begin
      rd_addr_d = rd_addr_q + 1'b1;
      if (!kx_max) begin
        kx_d = kx_q + 1'b1;
      end else begin
        kx_d = '0;
        if (!ky_max) begin
          ky_d      = ky_q + 1'b1;
          rd_addr_d = rd_addr_q + STEP_ROW;
        end else begin
          ky_d = '0;
          if (!ox_max) begin
            ox_d      = ox_q + 1'b1;
            rd_addr_d = rd_addr_q + STEP_WIN;
          end else begin
            ox_d = '0;
            if (!oy_max) begin
              oy_d = oy_q + 1'b1;
            end else begin
              oy_d = '0;
              c_d  = c_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    out_cnt_d = launch ? '0 : out_cnt_q;
    if (tag_out.valid) begin
      acc_d = tag_out.first ? rd_sample : win_max;
      if (tag_out.last) begin
        wr_en_d   = 1'b1;
        wr_addr_d = out_cnt_q;
        wr_data_d = win_max;
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      kx_q      <= '0;
      ky_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      c_q       <= '0;
      rd_addr_q <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      out_cnt_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      c_q       <= c_d;
      rd_addr_q <= rd_addr_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Tag stages track rd_data through the BRAM latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: this small array is reset explicitly; stale tags would otherwise fire writes after an abort.
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_pool_window_engine.sv
// Directed bench for pool_window_engine: two configurations checked cycle by cycle against a
// window-level reference model, with literal expectations pinning the model.
module tb_pool_window_engine;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pool_window_engine_if #(.DATA_W(8), .ADDR_IN_W(10), .ADDR_OUT_W(8)) if_a ();
  pool_window_engine_if #(.DATA_W(8), .ADDR_IN_W(10), .ADDR_OUT_W(8)) if_b ();

  pool_window_engine #(
    .IMG_W(4), .IMG_H(4), .CHANNELS(1), .POOL_K(2), .DATA_W(8),
    .RD_LAT(1), .ADDR_IN_W(10), .ADDR_OUT_W(8)
  ) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));

  pool_window_engine #(
    .IMG_W(6), .IMG_H(6), .CHANNELS(2), .POOL_K(3), .DATA_W(8),
    .RD_LAT(2), .ADDR_IN_W(10), .ADDR_OUT_W(8)
  ) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));

  // Geometry per configuration: index 0 = dut_a, 1 = dut_b.
  int gw [2] = '{4, 6};
  int gh [2] = '{4, 6};
  int gc [2] = '{1, 2};
  int gk [2] = '{2, 3};
  int gl [2] = '{1, 2};

  int mem [2][1024];

  // BRAM models with the configured read latency.
  logic [7:0] pa0, pb0, pb1;
  always @(posedge clk) begin
    if (if_a.rd_en) pa0 <= 8'(mem[0][if_a.rd_addr]);
    if (if_b.rd_en) pb0 <= 8'(mem[1][if_b.rd_addr]);
    pb1 <= pb0;
  end
  assign if_a.rd_data = pa0;
  assign if_b.rd_data = pb1;

  logic              obs_busy [2], obs_done [2], obs_rd_en [2], obs_wr_en [2];
  logic signed [31:0] obs_rd_addr [2], obs_wr_addr [2], obs_wr_data [2];
  assign obs_busy[0]    = if_a.busy;
  assign obs_done[0]    = if_a.done;
  assign obs_rd_en[0]   = if_a.rd_en;
  assign obs_wr_en[0]   = if_a.wr_en;
  assign obs_rd_addr[0] = 32'(if_a.rd_addr);
  assign obs_wr_addr[0] = 32'(if_a.wr_addr);
  assign obs_wr_data[0] = 32'(signed'(if_a.wr_data));
  assign obs_busy[1]    = if_b.busy;
  assign obs_done[1]    = if_b.done;
  assign obs_rd_en[1]   = if_b.rd_en;
  assign obs_wr_en[1]   = if_b.wr_en;
  assign obs_rd_addr[1] = 32'(if_b.rd_addr);
  assign obs_wr_addr[1] = 32'(if_b.wr_addr);
  assign obs_wr_data[1] = 32'(signed'(if_b.wr_data));

  // Reference model: expected outputs per cycle of a frame (cycle 0 = start sampled).
  bit exp_busy [2][128];
  bit exp_done [2][128];
  bit exp_rd_en [2][128];
  bit exp_wr_en [2][128];
  int exp_rd_addr [2][128];
  int exp_wr_addr [2][128];
  int exp_wr_data [2][128];
  int n_last [2];

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;
  ev_t wr_log [$];
  int  rd_log [$];
  int  done_log [$];

  int  checks = 0;
  int  errors = 0;
  bit  active [2] = '{1'b0, 1'b0};
  int  cyc [2] = '{0, 0};

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic build_model(input int d);
    int w, h, nc, k, l, n, t, win, a, m, wc;
    w = gw[d]; h = gh[d]; nc = gc[d]; k = gk[d]; l = gl[d];
    n = nc * w * h;
    n_last[d] = n + l + 2;
    for (int i = 0; i < 128; i++) begin
      exp_busy[d][i] = 0; exp_done[d][i] = 0; exp_rd_en[d][i] = 0; exp_wr_en[d][i] = 0;
      exp_rd_addr[d][i] = 0; exp_wr_addr[d][i] = 0; exp_wr_data[d][i] = 0;
    end
    t = 1;
    win = 0;
    for (int ch = 0; ch < nc; ch++)
      for (int oy = 0; oy < h / k; oy++)
        for (int ox = 0; ox < w / k; ox++) begin
          m = -1000;
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              a = ch * w * h + (oy * k + ky) * w + ox * k + kx;
              exp_rd_en[d][t] = 1;
              exp_rd_addr[d][t] = a;
              if (mem[d][a] > m) m = mem[d][a];
              t++;
            end
          wc = (t - 1) + l + 1;
          exp_wr_en[d][wc] = 1;
          exp_wr_addr[d][wc] = win;
          exp_wr_data[d][wc] = m;
          win++;
        end
    for (int i = 1; i <= n + l + 1; i++) exp_busy[d][i] = 1;
    exp_done[d][n + l + 2] = 1;
  endtask

  // Single compare process: every cycle of an active frame, at the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (active[d]) begin
        int k;
        string p;
        k = cyc[d];
        p = $sformatf("%s c%0d", (d == 0) ? "A" : "B", k);
        check({p, " busy"},  obs_busy[d],  exp_busy[d][k]);
        check({p, " done"},  obs_done[d],  exp_done[d][k]);
        check({p, " rd_en"}, obs_rd_en[d], exp_rd_en[d][k]);
        check({p, " wr_en"}, obs_wr_en[d], exp_wr_en[d][k]);
        if (exp_rd_en[d][k]) check({p, " rd_addr"}, obs_rd_addr[d], exp_rd_addr[d][k]);
        if (exp_wr_en[d][k]) begin
          check({p, " wr_addr"}, obs_wr_addr[d], exp_wr_addr[d][k]);
          check({p, " wr_data"}, obs_wr_data[d], exp_wr_data[d][k]);
        end
        if (obs_rd_en[d] === 1'b1) rd_log.push_back(obs_rd_addr[d]);
        if (obs_wr_en[d] === 1'b1) wr_log.push_back('{k, obs_wr_addr[d], obs_wr_data[d]});
        if (obs_done[d] === 1'b1) done_log.push_back(k);
      end
    end
  end

  task automatic set_start(input int d, input logic v);
    if (d == 0) if_a.start = v;
    else        if_b.start = v;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    done_log.delete();
  endtask

  task automatic check_all_zero(input int d, input string tag);
    check({tag, " busy"},    obs_busy[d],    0);
    check({tag, " done"},    obs_done[d],    0);
    check({tag, " rd_en"},   obs_rd_en[d],   0);
    check({tag, " rd_addr"}, obs_rd_addr[d], 0);
    check({tag, " wr_en"},   obs_wr_en[d],   0);
    check({tag, " wr_addr"}, obs_wr_addr[d], 0);
    check({tag, " wr_data"}, obs_wr_data[d], 0);
  endtask

  // Entered and left 1 time unit after a rising edge (start of a cycle).
  task automatic idle_cycles(input int d, input int n);
    set_start(d, 1'b0);
    cyc[d] = n_last[d] + 1;
    active[d] = 1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    active[d] = 0;
  endtask

  task automatic run_frame(input int d, input bit hold, input bit extra, input int abort_at);
    for (int k = 0; k <= n_last[d]; k++) begin
      if (abort_at != 0 && k == abort_at) begin
        active[d] = 0;
        rstn = 1'b0;
        #1;
        check_all_zero(d, "abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      cyc[d] = k;
      active[d] = 1;
      set_start(d, (k == 0) || hold || (extra && (k == 3 || k == 19)));
      @(posedge clk);
      #1;
    end
    active[d] = 0;
  endtask

  task automatic init_mem();
    int v;
    for (int a = 0; a < 1024; a++) begin
      mem[0][a] = (a < 16) ? a - 8 : 0;
      v = (a * 37) % 256;
      mem[1][a] = (v > 127) ? v - 256 : v;
    end
  endtask

  int pin_cyc [4] = '{6, 10, 14, 18};
  int pin_dat [4] = '{-3, -1, 5, 7};
  int pin_rd  [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    init_mem();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(0, "A reset");
    check_all_zero(1, "B reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Default 4x4 frame, pinned against the hand-worked sequence.
    build_model(0);
    clear_logs();
    run_frame(0, 0, 0, 0);
    idle_cycles(0, 2);
    check("A pin nrd", rd_log.size(), 16);
    for (int i = 0; i < 16 && i < rd_log.size(); i++)
      check($sformatf("A pin rd%0d", i), rd_log[i], pin_rd[i]);
    check("A pin nwr", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      check($sformatf("A pin wr%0d cyc", i),  wr_log[i].cyc,  pin_cyc[i]);
      check($sformatf("A pin wr%0d addr", i), wr_log[i].addr, i);
      check($sformatf("A pin wr%0d data", i), wr_log[i].data, pin_dat[i]);
    end
    check("A pin ndone", done_log.size(), 1);
    if (done_log.size() > 0) check("A pin done cyc", done_log[0], 19);

    // All-negative and tie windows.
    mem[0][0] = -128; mem[0][1] = -1; mem[0][4] = -128; mem[0][5] = -2;
    mem[0][2] = 5;    mem[0][3] = 5;  mem[0][6] = 5;    mem[0][7] = 5;
    build_model(0);
    clear_logs();
    run_frame(0, 0, 0, 0);
    idle_cycles(0, 2);
    if (wr_log.size() >= 2) begin
      check("A neg window", wr_log[0].data, -1);
      check("A tie window", wr_log[1].data, 5);
    end else begin
      check("A neg/tie nwr", wr_log.size(), 4);
    end

    // Start re-pulsed at cycles 3 and 19, then a fresh start at cycle 20.
    init_mem();
    build_model(0);
    clear_logs();
    run_frame(0, 0, 1, 0);
    run_frame(0, 0, 0, 0);
    idle_cycles(0, 3);
    check("A restart ndone", done_log.size(), 2);
    check("A restart nwr", wr_log.size(), 8);

    // Reset mid-frame, then a full frame after release.
    clear_logs();
    run_frame(0, 0, 0, 9);
    idle_cycles(0, 8);
    check("A abort writes", wr_log.size(), 1);
    run_frame(0, 0, 0, 0);
    idle_cycles(0, 2);
    check("A post-abort nwr", wr_log.size(), 5);

    // Start held high: frames separated by a single IDLE cycle.
    clear_logs();
    run_frame(0, 1, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(0, 1, 0, 0);
    idle_cycles(0, 3);
    check("A b2b ndone", done_log.size(), 3);

    // 6x6, K=3, two channels, read latency 2.
    build_model(1);
    clear_logs();
    run_frame(1, 0, 0, 0);
    idle_cycles(1, 3);
    check("B nrd", rd_log.size(), 72);
    check("B nwr", wr_log.size(), 8);
    if (wr_log.size() == 8) begin
      check("B first wr cyc", wr_log[0].cyc, 12);
      check("B first wr data", wr_log[0].data, 74);
      check("B last wr cyc", wr_log[7].cyc, 75);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
